cdb_result_buffer: RTL

- Complete-stage buffer between the functional units and the CDB.
- Holds one finished result per FU and presents them as the per-FU `fu_result_valid` vector to the FU selector.
- Consumes the selector's `fu_num` / `cat_select` grant and drives one registered CDB broadcast per cycle.
- Frees the granted slot and back-pressures any FU whose slot is still occupied.

---
 rtl/cdb_result_buffer.sv | 104 ++++++++++
 1 files changed

// File: rtl/cdb_result_buffer.sv
// cdb_result_buffer: complete-stage holding buffer between the FUs and the CDB.
// Ports: clock/reset (sync, active-high), squash, fu_done/fu_value/fu_tag/
//   fu_br_taken (per-FU results in), fu_num/cat_select (selector grant in),
//   fu_result_valid (slot occupancy out), fu_stall (per-FU hold out),
//   cdb_valid/cdb_tag/cdb_value/cdb_br_taken/cdb_fu_num (registered broadcast).
module cdb_result_buffer #(
    parameter int FU_SIZE = 20,
    parameter int XLEN    = 32,
    parameter int TAG_W   = 5
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     squash,
    input  logic [FU_SIZE-1:0]       fu_done,
    input  logic [FU_SIZE*XLEN-1:0]  fu_value,
    input  logic [FU_SIZE*TAG_W-1:0] fu_tag,
    input  logic [FU_SIZE-1:0]       fu_br_taken,
    input  logic [4:0]               fu_num,
    input  logic [3:0]               cat_select,
    output logic [FU_SIZE-1:0]       fu_result_valid,
    output logic [FU_SIZE-1:0]       fu_stall,
    output logic                     cdb_valid,
    output logic [TAG_W-1:0]         cdb_tag,
    output logic [XLEN-1:0]          cdb_value,
    output logic                     cdb_br_taken,
    output logic [4:0]               cdb_fu_num
);

    logic [FU_SIZE-1:0] r_valid;
    logic [XLEN-1:0]    r_value [FU_SIZE];
    logic [TAG_W-1:0]   r_tag   [FU_SIZE];
    logic [FU_SIZE-1:0] r_br;

    logic [FU_SIZE-1:0] w_grant;
    logic [FU_SIZE-1:0] w_cap;
    logic               w_any_grant;
    logic [XLEN-1:0]    w_sel_value;
    logic [TAG_W-1:0]   w_sel_tag;
    logic               w_sel_br;

    // A grant only counts when it names an occupied slot; out-of-range
    // indices never match any slot and so fall out as no-ops.
    always_comb begin
        w_grant = '0;
        for (int i = 0; i < FU_SIZE; i++) begin
            w_grant[i] = (cat_select != 4'd0) && (fu_num == 5'(i)) && r_valid[i];
        end
    end

    assign w_any_grant     = |w_grant;
    assign fu_stall        = r_valid & ~w_grant;
    assign w_cap           = fu_done & ~fu_stall & {FU_SIZE{~squash}};
    assign fu_result_valid = r_valid;

    // w_grant is at most one-hot, so an OR-mux selects the slot contents.
    always_comb begin
        w_sel_value = '0;
        w_sel_tag   = '0;
        w_sel_br    = 1'b0;
        for (int i = 0; i < FU_SIZE; i++) begin
            if (w_grant[i]) begin
                w_sel_value = w_sel_value | r_value[i];
                w_sel_tag   = w_sel_tag | r_tag[i];
                w_sel_br    = w_sel_br | r_br[i];
            end
        end
    end

    // Slot payload needs no reset: it is only observed while valid.
    always_ff @(posedge clock) begin
        for (int i = 0; i < FU_SIZE; i++) begin
            if (w_cap[i]) begin
                r_value[i] <= fu_value[i*XLEN +: XLEN];
                r_tag[i]   <= fu_tag[i*TAG_W +: TAG_W];
                r_br[i]    <= fu_br_taken[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid      <= '0;
            cdb_valid    <= 1'b0;
            cdb_tag      <= '0;
            cdb_value    <= '0;
            cdb_br_taken <= 1'b0;
            cdb_fu_num   <= '0;
        end else if (squash) begin
            r_valid   <= '0;
            cdb_valid <= 1'b0;
        end else begin
            // A same-cycle capture refills a slot that is being released.
            r_valid   <= (r_valid & ~w_grant) | w_cap;
            cdb_valid <= w_any_grant;
            if (w_any_grant) begin
                cdb_tag      <= w_sel_tag;
                cdb_value    <= w_sel_value;
                cdb_br_taken <= w_sel_br;
                cdb_fu_num   <= fu_num;
            end
        end
    end

endmodule
